// File: rtl/cpu_pkg.sv
// Shared CPU pipeline encodings: writeback source select, MEM-stage FSM states, MEM/WB payload.
package cpu_pkg;

  localparam logic [1:0] WESL_ALU     = 2'b00;
  localparam logic [1:0] WESL_DRAM    = 2'b01;
  localparam logic [1:0] WESL_PC4     = 2'b10;
  localparam logic [1:0] WESL_ALU_ALT = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef struct packed {
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        we;
    logic        have_inst;
  } memwb_t;

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register, one cycle of latency.
// A bubble clears we/have_inst and holds every other field.
module reg_mem_wb
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_bubble,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.we        <= 1'b0;
      r_q.have_inst <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: DRAM request FSM with timeout/misalign handling, writeback mux, MEM/WB register.
// Zero added latency when dram_ack arrives with the request; otherwise mem_stall holds upstream.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_rd2,
  input  logic [31:0] mem_aluC,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_pc,
  input  logic [1:0]  mem_rf_wesl,
  input  logic        mem_dram_we,
  input  logic        mem_we,
  input  logic        mem_have_inst,
  input  logic [4:0]  mem_wr,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_fwd_data,
  output logic [31:0] wb_wd,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_wr,
  output logic        wb_we,
  output logic        wb_have_inst,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_bus_err;
  logic          r_mis_err;

  logic          w_access;
  logic          w_idle;
  logic          w_in_wait;
  logic          w_misalign;
  logic          w_idle_req;
  logic          w_timeout;
  logic          w_req;
  logic          w_stall;
  logic [31:0]   w_load;
  memwb_t        w_wb_d;
  memwb_t        w_wb_q;

  assign w_access   = mem_have_inst & (mem_dram_we | (mem_rf_wesl == WESL_DRAM));
  assign w_idle     = (r_state == ST_IDLE);
  assign w_in_wait  = (r_state == ST_WAIT);
  assign w_misalign = w_idle & w_access & (mem_aluC[1:0] != 2'b00);
  assign w_idle_req = w_idle & w_access & ~w_misalign;
  assign w_timeout  = w_in_wait & ~dram_ack & (r_cnt == CNT_LAST);
  assign w_req      = w_idle_req | w_in_wait;
  assign w_stall    = w_req & ~dram_ack & ~w_timeout;

  // Reset gates the bus so an in-flight request is dropped the instant rst_n falls.
  assign dram_req   = rst_n & w_req;
  assign dram_we    = rst_n & (w_in_wait ? r_we : (w_idle_req & mem_dram_we));
  assign dram_addr  = !rst_n ? 32'd0 : (w_in_wait ? r_addr : mem_aluC);
  assign dram_wdata = !rst_n ? 32'd0 : (w_in_wait ? r_wdata : mem_rd2);
  assign mem_stall  = rst_n & w_stall;

  assign w_load       = (w_timeout | w_misalign) ? 32'd0 : dram_rdata;
  assign mem_fwd_data = (mem_rf_wesl == WESL_PC4) ? mem_pc4 : mem_aluC;

  always_comb begin
    w_wb_d           = '0;
    w_wb_d.pc        = mem_pc;
    w_wb_d.wr        = mem_wr;
    w_wb_d.we        = mem_we & ~w_misalign;
    w_wb_d.have_inst = mem_have_inst;
    case (mem_rf_wesl)
      WESL_DRAM: w_wb_d.wd = w_load;
      WESL_PC4:  w_wb_d.wd = mem_pc4;
      default:   w_wb_d.wd = mem_aluC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_bus_err <= 1'b0;
      r_mis_err <= 1'b0;
    end else begin
      if (w_idle_req && !dram_ack) begin
        r_state <= ST_WAIT;
        r_cnt   <= '0;
        r_addr  <= mem_aluC;
        r_wdata <= mem_rd2;
        r_we    <= mem_dram_we;
      end else if (w_in_wait) begin
        if (dram_ack || w_timeout) r_state <= ST_IDLE;
        else                       r_cnt   <= r_cnt + 1'b1;
      end
      if (w_timeout)  r_bus_err <= 1'b1;
      if (w_misalign) r_mis_err <= 1'b1;
    end
  end

  assign bus_err      = r_bus_err;
  assign misalign_err = r_mis_err;

  reg_mem_wb u_reg_mem_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (w_stall),
    .i_d      (w_wb_d),
    .o_q      (w_wb_q)
  );

  assign wb_wd        = w_wb_q.wd;
  assign wb_pc        = w_wb_q.pc;
  assign wb_wr        = w_wb_q.wr;
  assign wb_we        = w_wb_q.we;
  assign wb_have_inst = w_wb_q.have_inst;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected writebacks plus immediate checks on bus/stall.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_rd2, mem_aluC, mem_pc4, mem_pc;
  logic [1:0]  mem_rf_wesl;
  logic        mem_dram_we, mem_we, mem_have_inst;
  logic [4:0]  mem_wr;
  logic        dram_req, dram_we;
  logic [31:0] dram_addr, dram_wdata;
  logic        dram_ack;
  logic [31:0] dram_rdata;
  logic        mem_stall;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_wd, wb_pc;
  logic [4:0]  wb_wr;
  logic        wb_we, wb_have_inst;
  logic        bus_err, misalign_err;

  typedef struct {
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd2(mem_rd2), .mem_aluC(mem_aluC), .mem_pc4(mem_pc4), .mem_pc(mem_pc),
    .mem_rf_wesl(mem_rf_wesl), .mem_dram_we(mem_dram_we), .mem_we(mem_we),
    .mem_have_inst(mem_have_inst), .mem_wr(mem_wr),
    .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_ack(dram_ack), .dram_rdata(dram_rdata),
    .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
    .wb_wd(wb_wd), .wb_pc(wb_pc), .wb_wr(wb_wr), .wb_we(wb_we), .wb_have_inst(wb_have_inst),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic have, input logic [1:0] wesl, input logic dwe, input logic we,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [31:0] pc);
    mem_have_inst = have;
    mem_rf_wesl   = wesl;
    mem_dram_we   = dwe;
    mem_we        = we;
    mem_wr        = wr;
    mem_aluC      = alu;
    mem_rd2       = rd2;
    mem_pc        = pc;
    mem_pc4       = pc + 32'd4;
  endtask

  task automatic bubble();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic push(input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] wr, input logic we);
    exp_t e;
    e.wd = wd; e.pc = pc; e.wr = wr; e.we = we;
    exp_q.push_back(e);
  endtask

  // One clock: after the rising edge, any writeback must match the oldest expected entry.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (wb_have_inst === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL wb_unexpected: observed writeback wd=%h expected none", wb_wd);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_wd", wb_wd, e.wd);
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_wr", {27'd0, wb_wr}, {27'd0, e.wr});
        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    dram_ack = 1'b0;
    dram_rdata = 32'd0;
    bubble();
    repeat (2) @(negedge clk);
    chk("rst_wb_wd", wb_wd, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_have", {31'd0, wb_have_inst}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mis_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_req", {31'd0, dram_req}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Load with immediate ack: no stall, data on wb next cycle.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0, 32'h1000);
    dram_ack = 1'b1;
    dram_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_req", {31'd0, dram_req}, 32'd1);
    chk("ld_addr", dram_addr, 32'h100);
    chk("ld_dwe", {31'd0, dram_we}, 32'd0);
    chk("ld_stall", {31'd0, mem_stall}, 32'd0);
    chk("ld_fwd", mem_fwd_data, 32'h100);
    push(32'hDEADBEEF, 32'h1000, 5'd5, 1'b1);
    cyc();
    chk("ld_wb_we", {31'd0, wb_we}, 32'd1);
    bubble();
    dram_ack = 1'b0;

    // Store at 0x200 with ack arriving after 3 stalled cycles.
    drive(1'b1, 2'b00, 1'b1, 1'b0, 5'd0, 32'h200, 32'hCAFEF00D, 32'h2000);
    push(32'h200, 32'h2000, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", {31'd0, mem_stall}, 32'd1);
      chk("st_req", {31'd0, dram_req}, 32'd1);
      chk("st_addr", dram_addr, 32'h200);
      chk("st_wdata", dram_wdata, 32'hCAFEF00D);
      chk("st_dwe", {31'd0, dram_we}, 32'd1);
      cyc();
      chk("st_bubble", {31'd0, wb_have_inst}, 32'd0);
    end
    dram_ack = 1'b1;
    #1;
    chk("st_ack_stall", {31'd0, mem_stall}, 32'd0);
    cyc();
    chk("st_wb_have", {31'd0, wb_have_inst}, 32'd1);
    dram_ack = 1'b0;
    bubble();

    // Ack with no request is ignored.
    dram_ack = 1'b1;
    #1;
    chk("stray_req", {31'd0, dram_req}, 32'd0);
    chk("stray_stall", {31'd0, mem_stall}, 32'd0);
    cyc();
    chk("stray_wb", {31'd0, wb_have_inst}, 32'd0);
    dram_ack = 1'b0;

    // Load that never gets ack: forced completion on the 4th WAIT cycle.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 5'd7, 32'h300, 32'h0, 32'h3000);
    dram_rdata = 32'h12345678;
    push(32'h0, 32'h3000, 5'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", {31'd0, mem_stall}, 32'd1);
      cyc();
    end
    #1;
    chk("to_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("to_err_pre", {31'd0, bus_err}, 32'd0);
    cyc();
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    bubble();
    #1;
    chk("to_req_drop", {31'd0, dram_req}, 32'd0);
    cyc();
    chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Misaligned load: no request, no stall, we suppressed.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 5'd9, 32'h102, 32'h0, 32'h4000);
    dram_rdata = 32'h55AA55AA;
    #1;
    chk("mis_req", {31'd0, dram_req}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    push(32'h0, 32'h4000, 5'd9, 1'b0);
    cyc();
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_wb_we", {31'd0, wb_we}, 32'd0);
    bubble();
    cyc();

    // JAL-style writeback of pc4, forwarded in the same cycle.
    drive(1'b1, 2'b10, 1'b0, 1'b1, 5'd31, 32'h999, 32'h0, 32'h40);
    #1;
    chk("jal_fwd", mem_fwd_data, 32'h44);
    chk("jal_req", {31'd0, dram_req}, 32'd0);
    push(32'h44, 32'h40, 5'd31, 1'b1);
    cyc();
    chk("jal_wb_wd", wb_wd, 32'h44);
    bubble();
    cyc();

    // Reset on the 2nd WAIT cycle abandons the access.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 5'd3, 32'h400, 32'h0, 32'h5000);
    cyc();
    cyc();
    #1;
    chk("rw_req_pre", {31'd0, dram_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", {31'd0, dram_req}, 32'd0);
    chk("rw_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_wb_wd", wb_wd, 32'd0);
    chk("rw_wb_have", {31'd0, wb_have_inst}, 32'd0);
    chk("rw_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rw_mis_err", {31'd0, misalign_err}, 32'd0);
    cyc();
    bubble();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("rw_no_wb", {31'd0, wb_have_inst}, 32'd0);
    chk("rw_req_post", {31'd0, dram_req}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
